// File: rtl/pippo_mul_uu.sv
// Iterative unsigned a_width x a_width multiplier (radix-2 shift-add) for the pippo execution unit.
// Start/busy/done handshake; flush aborts an in-flight operation without touching p/ovf.
module pippo_mul_uu #(
    parameter  int unsigned a_width = 32,
    localparam int unsigned p_width = 2 * a_width
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               flush,
    input  logic [a_width-1:0] a,
    input  logic [a_width-1:0] b,
    output logic [p_width-1:0] p,
    output logic               ovf,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CW = $clog2(a_width);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [a_width-1:0]   mcand_q, mcand_d;
    logic [a_width-1:0]   mplr_q,  mplr_d;
    logic [p_width:0]     acc_q,   acc_d;
    logic [CW-1:0]        cnt_q,   cnt_d;
    logic [p_width-1:0]   p_q,     p_d;
    logic                 ovf_q,   ovf_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;

    logic [a_width:0]     sum;
    logic                 start_ok;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        start_ok = start & ~busy_q & ~flush;

        // Upper accumulator half plus the conditional multiplicand; the extra bit is the kept carry.
        sum = acc_q[p_width:a_width] + (mplr_q[0] ? {1'b0, mcand_q} : (a_width + 1)'(0));

        if (flush) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        if ((a == '0) || (b == '0)) begin
                            p_d    = '0;
                            ovf_d  = 1'b0;
                            done_d = 1'b1;
                        end else begin
                            mcand_d = a;
                            mplr_d  = b;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = RUN;
                            busy_d  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc_d  = {sum, acc_q[a_width-1:0]} >> 1;
                    mplr_d = mplr_q >> 1;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(a_width - 1)) begin
                        p_d     = acc_d[p_width-1:0];
                        ovf_d   = |acc_d[p_width-1:a_width];
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign p    = p_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
